// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, sync polarity encodings and the control bundle that is
// carried alongside pixel data through the display pipeline.
package vga_timing_pkg;

    // 640x480 @ 60 Hz, 25 MHz pixel clock
    localparam int VGA640_WIDTH  = 640;
    localparam int VGA640_H_FP   = 16;
    localparam int VGA640_H_SYNC = 96;
    localparam int VGA640_H_BP   = 48;
    localparam int VGA640_HEIGHT = 480;
    localparam int VGA640_V_FP   = 10;
    localparam int VGA640_V_SYNC = 2;
    localparam int VGA640_V_BP   = 33;

    localparam logic ACTIVE_LOW  = 1'b0;
    localparam logic ACTIVE_HIGH = 1'b1;

    typedef struct packed {
        logic valid;
        logic hs;
        logic vs;
    } vga_ctl_t;

    function automatic int total_len(input int active, input int fp, input int sync,
                                     input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth shift register with synchronous reset; DEPTH=0 is a plain wire.
module pipe_delay #(
    parameter int unsigned   DW      = 1,
    parameter int unsigned   DEPTH   = 1,
    parameter logic [DW-1:0] RST_VAL = '0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [DW-1:0] d_i,
    output logic [DW-1:0] q_o
);

    if (DEPTH == 0) begin : gen_wire
        logic unused_ctrl;
        assign unused_ctrl = clk_i ^ rst_i;
        assign q_o         = d_i;
    end else begin : gen_shift
        logic [DW-1:0] stage_q [DEPTH];

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= RST_VAL;
            end else begin
                stage_q[0] <= d_i;
                for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_display_pipe.sv
// VGA timing generator with a latency-matched, blanked and registered RGB/sync output stage.
module vga_display_pipe
    import vga_timing_pkg::*;
#(
    parameter int          WIDTH    = VGA640_WIDTH,
    parameter int          HEIGHT   = VGA640_HEIGHT,
    parameter int          H_FP     = VGA640_H_FP,
    parameter int          H_SYNC   = VGA640_H_SYNC,
    parameter int          H_BP     = VGA640_H_BP,
    parameter int          V_FP     = VGA640_V_FP,
    parameter int          V_SYNC   = VGA640_V_SYNC,
    parameter int          V_BP     = VGA640_V_BP,
    parameter logic        H_POL    = ACTIVE_LOW,
    parameter logic        V_POL    = ACTIVE_LOW,
    parameter int unsigned RGB_BITS = 4,
    parameter int unsigned RGB_LAT  = 0
) (
    input  logic                      clk_25,
    input  logic                      reset,
    input  logic [RGB_BITS-1:0]       Red_level,
    input  logic [RGB_BITS-1:0]       Green_level,
    input  logic [RGB_BITS-1:0]       Blue_level,
    output logic [$clog2(WIDTH)-1:0]  pxl_x,
    output logic [$clog2(HEIGHT)-1:0] pxl_y,
    output logic                      pxl_valid,
    output logic                      vblank_start,
    output logic [RGB_BITS-1:0]       Red,
    output logic [RGB_BITS-1:0]       Green,
    output logic [RGB_BITS-1:0]       Blue,
    output logic                      disp_ena,
    output logic                      h_sync,
    output logic                      v_sync
);

    if (WIDTH <= 0 || HEIGHT <= 0 || H_SYNC <= 0 || V_SYNC <= 0 ||
        H_FP < 0 || H_BP < 0 || V_FP < 0 || V_BP < 0) begin : gen_bad_cfg
        $error("vga_display_pipe: invalid timing parameters");
    end

    localparam int H_TOTAL = total_len(WIDTH, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = total_len(HEIGHT, V_FP, V_SYNC, V_BP);
    localparam int HCW     = $clog2(H_TOTAL);
    localparam int VCW     = $clog2(V_TOTAL);
    localparam int XW      = $clog2(WIDTH);
    localparam int YW      = $clog2(HEIGHT);

    localparam logic [HCW-1:0] H_MAX  = HCW'(H_TOTAL - 1);
    localparam logic [HCW-1:0] H_ACT  = HCW'(WIDTH);
    localparam logic [HCW-1:0] HS_BEG = HCW'(WIDTH + H_FP);
    localparam logic [HCW-1:0] HS_END = HCW'(WIDTH + H_FP + H_SYNC - 1);
    localparam logic [VCW-1:0] V_MAX  = VCW'(V_TOTAL - 1);
    localparam logic [VCW-1:0] V_ACT  = VCW'(HEIGHT);
    localparam logic [VCW-1:0] VS_BEG = VCW'(HEIGHT + V_FP);
    localparam logic [VCW-1:0] VS_END = VCW'(HEIGHT + V_FP + V_SYNC - 1);

    logic [HCW-1:0] h_cnt_q, h_cnt_d;
    logic [VCW-1:0] v_cnt_q, v_cnt_d;

    always_comb begin
        h_cnt_d = h_cnt_q + HCW'(1);
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_MAX) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_MAX) ? '0 : v_cnt_q + VCW'(1);
        end
    end

    always_ff @(posedge clk_25) begin
        if (reset) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Stage 0: pure decode of the counter registers
    vga_ctl_t ctl_raw, ctl_dly;

    always_comb begin
        ctl_raw.valid = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        ctl_raw.hs    = (h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END);
        ctl_raw.vs    = (v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END);
    end

    assign pxl_valid    = ctl_raw.valid;
    assign pxl_x        = ctl_raw.valid ? h_cnt_q[XW-1:0] : '0;
    assign pxl_y        = ctl_raw.valid ? v_cnt_q[YW-1:0] : '0;
    assign vblank_start = (h_cnt_q == '0) && (v_cnt_q == V_ACT);

    // Control bits wait RGB_LAT cycles so they line up with the drawing logic's colour
    pipe_delay #(
        .DW     ($bits(vga_ctl_t)),
        .DEPTH  (RGB_LAT),
        .RST_VAL('0)
    ) u_ctl_delay (
        .clk_i(clk_25),
        .rst_i(reset),
        .d_i  (ctl_raw),
        .q_o  (ctl_dly)
    );

    logic [RGB_BITS-1:0] red_q, green_q, blue_q;
    logic                de_q, hs_q, vs_q;

    always_ff @(posedge clk_25) begin
        if (reset) begin
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
            de_q    <= 1'b0;
            hs_q    <= ~H_POL;
            vs_q    <= ~V_POL;
        end else begin
            red_q   <= ctl_dly.valid ? Red_level   : '0;
            green_q <= ctl_dly.valid ? Green_level : '0;
            blue_q  <= ctl_dly.valid ? Blue_level  : '0;
            de_q    <= ctl_dly.valid;
            hs_q    <= ctl_dly.hs ? H_POL : ~H_POL;
            vs_q    <= ctl_dly.vs ? V_POL : ~V_POL;
        end
    end

    assign Red      = red_q;
    assign Green    = green_q;
    assign Blue     = blue_q;
    assign disp_ena = de_q;
    assign h_sync   = hs_q;
    assign v_sync   = vs_q;

endmodule

// File: tb/tb_vga_display_pipe.sv
// Directed bench: default 640x480 pipe (RGB_LAT=0) plus a tiny 14x7 pipe (RGB_LAT=2,
// H_POL=1) that wraps many frames and takes a mid-frame reset.
module tb_vga_display_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;

    // Instance A: defaults, colour inputs held at F
    logic [9:0] a_x;
    logic [8:0] a_y;
    logic       a_valid, a_vbl, a_de, a_hs, a_vs;
    logic [3:0] a_r, a_g, a_b;

    vga_display_pipe u_dut_a (
        .clk_25      (clk),
        .reset       (rst_a),
        .Red_level   (4'hF),
        .Green_level (4'hF),
        .Blue_level  (4'hF),
        .pxl_x       (a_x),
        .pxl_y       (a_y),
        .pxl_valid   (a_valid),
        .vblank_start(a_vbl),
        .Red         (a_r),
        .Green       (a_g),
        .Blue        (a_b),
        .disp_ena    (a_de),
        .h_sync      (a_hs),
        .v_sync      (a_vs)
    );

    // Instance B: small config, Red_level = pxl_x returned two cycles late
    logic [2:0] b_x, b_x_d1, b_x_d2;
    logic [1:0] b_y;
    logic       b_valid, b_vbl, b_de, b_hs, b_vs;
    logic [3:0] b_r, b_g, b_b, b_red_lvl;

    always @(posedge clk) begin
        b_x_d1 <= b_x;
        b_x_d2 <= b_x_d1;
    end
    assign b_red_lvl = {1'b0, b_x_d2};

    vga_display_pipe #(
        .WIDTH   (8),
        .HEIGHT  (4),
        .H_FP    (2),
        .H_SYNC  (3),
        .H_BP    (1),
        .V_FP    (1),
        .V_SYNC  (1),
        .V_BP    (1),
        .H_POL   (1'b1),
        .V_POL   (1'b0),
        .RGB_BITS(4),
        .RGB_LAT (2)
    ) u_dut_b (
        .clk_25      (clk),
        .reset       (rst_b),
        .Red_level   (b_red_lvl),
        .Green_level (4'h5),
        .Blue_level  (4'hA),
        .pxl_x       (b_x),
        .pxl_y       (b_y),
        .pxl_valid   (b_valid),
        .vblank_start(b_vbl),
        .Red         (b_r),
        .Green       (b_g),
        .Blue        (b_b),
        .disp_ena    (b_de),
        .h_sync      (b_hs),
        .v_sync      (b_vs)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // n = cycles since release; outputs at n reflect counter value n-1
    task automatic check_a(input int n);
        int h, v, ho;
        bit vld, de, hs;
        h   = n % 800;
        v   = n / 800;
        vld = (h < 640);
        chk($sformatf("A pxl_valid n=%0d", n), 32'(a_valid), 32'(vld));
        chk($sformatf("A pxl_x n=%0d", n), 32'(a_x), vld ? h : 0);
        chk($sformatf("A pxl_y n=%0d", n), 32'(a_y), vld ? v : 0);
        chk($sformatf("A vblank n=%0d", n), 32'(a_vbl), 0);
        if (n == 0) begin
            de = 1'b0;
            hs = 1'b1;
        end else begin
            ho = (n - 1) % 800;
            de = (ho < 640);
            hs = !(ho >= 656 && ho <= 751);
        end
        chk($sformatf("A disp_ena n=%0d", n), 32'(a_de), 32'(de));
        chk($sformatf("A h_sync n=%0d", n), 32'(a_hs), 32'(hs));
        chk($sformatf("A v_sync n=%0d", n), 32'(a_vs), 1);
        chk($sformatf("A rgb n=%0d", n), {20'd0, a_r, a_g, a_b}, de ? 32'hFFF : 32'h0);
    endtask

    // m = cycles since release; outputs at m reflect counter value m-3
    task automatic check_b(input int m);
        int c, h, v, t;
        bit vld, de, hs, vs;
        int red;
        c   = m % 98;
        h   = c % 14;
        v   = c / 14;
        vld = (h < 8) && (v < 4);
        chk($sformatf("B pxl_valid m=%0d", m), 32'(b_valid), 32'(vld));
        chk($sformatf("B pxl_x m=%0d", m), 32'(b_x), vld ? h : 0);
        chk($sformatf("B pxl_y m=%0d", m), 32'(b_y), vld ? v : 0);
        chk($sformatf("B vblank m=%0d", m), 32'(b_vbl), 32'(h == 0 && v == 4));
        if (m < 3) begin
            de  = 1'b0;
            hs  = 1'b0;
            vs  = 1'b1;
            red = 0;
        end else begin
            t   = m - 3;
            c   = t % 98;
            h   = c % 14;
            v   = c / 14;
            de  = (h < 8) && (v < 4);
            hs  = (h >= 10 && h <= 12);
            vs  = (v != 5);
            red = de ? h : 0;
        end
        chk($sformatf("B disp_ena m=%0d", m), 32'(b_de), 32'(de));
        chk($sformatf("B h_sync m=%0d", m), 32'(b_hs), 32'(hs));
        chk($sformatf("B v_sync m=%0d", m), 32'(b_vs), 32'(vs));
        chk($sformatf("B red m=%0d", m), 32'(b_r), red);
        chk($sformatf("B green m=%0d", m), 32'(b_g), de ? 5 : 0);
        chk($sformatf("B blue m=%0d", m), 32'(b_b), de ? 10 : 0);
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        // B is reset from cycle 1000 (stage 0 at h=6,v=1, output active) for three edges
        for (int i = 0; i <= 1700; i++) begin
            check_a(i);
            if (i >= 1001 && i <= 1003) check_b(0);
            else if (i < 1001) check_b(i);
            else check_b(i - 1003);
            if (i == 1000) rst_b = 1'b1;
            if (i == 1003) rst_b = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
